dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the pipeline MEM stage (CPU) and a DMA/debug loader port.
- Sits between the EX/MEM pipeline register and the data memory.
- Sequences multi-cycle reads and drives a pipeline stall to the CPU while its access is pending.
- CPU has default priority; a starvation counter guarantees the DMA port progress.

---
 rtl/dmem_port_arbiter_if.sv | 49 ++++
 rtl/dmem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundled CPU, DMA and data-memory signals of the shared data-memory port.
// The arbiter takes the slave view; the requesters and the memory model take the master view.
interface dmem_port_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DM_ADDRESS-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [2:0]            cpu_funct3;
  logic                  cpu_stall;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_rvalid;

  logic                  dma_req;
  logic                  dma_we;
  logic [DM_ADDRESS-1:0] dma_addr;
  logic [DATA_W-1:0]     dma_wdata;
  logic [2:0]            dma_funct3;
  logic                  dma_gnt;
  logic [DATA_W-1:0]     dma_rdata;
  logic                  dma_rvalid;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_funct3,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_funct3,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage and the DMA loader,
// sequencing multi-cycle reads and stalling the pipeline while a CPU access is pending.
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int RD_LAT     = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  localparam int              WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [2:0]      LAT_INIT = 3'(RD_LAT - 1);

  state_e                state_q, state_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [2:0]            lat_cnt_q, lat_cnt_d;
  logic                  owner_q, owner_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;

  logic                  cpuWin, dmaWin, cpuDone;
  logic                  memRd, memWr, cpuRvalid, dmaRvalid;
  logic                  selWe;
  logic [DM_ADDRESS-1:0] memAddr;
  logic [DATA_W-1:0]     memWdata;
  logic [2:0]            memFunct3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      funct3_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    cpuWin     = 1'b0;
    dmaWin     = 1'b0;
    memRd      = 1'b0;
    memWr      = 1'b0;
    selWe      = 1'b0;
    memAddr    = '0;
    memWdata   = '0;
    memFunct3  = '0;
    cpuRvalid  = 1'b0;
    dmaRvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        // CPU keeps priority until the DMA has lost MAX_WAIT arbitrations in a row
        cpuWin = bus.cpu_req & ~(bus.dma_req & (wait_cnt_q >= WAIT_MAX));
        dmaWin = bus.dma_req & ~cpuWin;
        if (cpuWin) begin
          selWe     = bus.cpu_we;
          memAddr   = bus.cpu_addr;
          memWdata  = bus.cpu_wdata;
          memFunct3 = bus.cpu_funct3;
        end else if (dmaWin) begin
          selWe     = bus.dma_we;
          memAddr   = bus.dma_addr;
          memWdata  = bus.dma_wdata;
          memFunct3 = bus.dma_funct3;
        end
        if (cpuWin || dmaWin) begin
          memWr = selWe;
          memRd = ~selWe;
          if (!selWe) begin
            addr_d    = memAddr;
            funct3_d  = memFunct3;
            owner_d   = dmaWin;
            lat_cnt_d = LAT_INIT;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        memRd     = 1'b1;
        memAddr   = addr_q;
        memFunct3 = funct3_q;
        if (lat_cnt_q == 3'd0) begin
          cpuRvalid = ~owner_q;
          dmaRvalid = owner_q;
          state_d   = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dmaWin || !bus.dma_req) begin
      wait_cnt_d = '0;
    end else if (cpuWin && (wait_cnt_q < WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    cpuDone = (cpuWin & selWe) | cpuRvalid;
  end

  // Every response is forced low while reset is held, independent of the registered state
  always_comb begin
    bus.cpu_stall  = ~reset & bus.cpu_req & ~cpuDone;
    bus.cpu_rvalid = ~reset & cpuRvalid;
    bus.cpu_rdata  = (~reset & cpuRvalid) ? bus.mem_rdata : '0;
    bus.dma_gnt    = ~reset & dmaWin;
    bus.dma_rvalid = ~reset & dmaRvalid;
    bus.dma_rdata  = (~reset & dmaRvalid) ? bus.mem_rdata : '0;
    bus.mem_rd     = ~reset & memRd;
    bus.mem_wr     = ~reset & memWr;
    bus.mem_addr   = reset ? '0 : memAddr;
    bus.mem_wdata  = reset ? '0 : memWdata;
    bus.mem_funct3 = reset ? '0 : memFunct3;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with RD_LAT=2/MAX_WAIT=3 and one with
// RD_LAT=1/MAX_WAIT=0, driven cycle by cycle with hand-computed expectations.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;

  dmem_port_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) u0If ();
  dmem_port_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) u1If ();

  dmem_port_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .RD_LAT(2), .MAX_WAIT(3)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (u0If.slave)
  );

  dmem_port_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .RD_LAT(1), .MAX_WAIT(0)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u1If.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [8:0] cAddr,
                               input logic [31:0] cWdata, input logic dReq, input logic dWe,
                               input logic [8:0] dAddr, input logic [31:0] dWdata);
    u0If.cpu_req   = cReq;
    u0If.cpu_we    = cWe;
    u0If.cpu_addr  = cAddr;
    u0If.cpu_wdata = cWdata;
    u0If.dma_req   = dReq;
    u0If.dma_we    = dWe;
    u0If.dma_addr  = dAddr;
    u0If.dma_wdata = dWdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    reset   = 1'b1;
    applyStimulus(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 1'b1, 1'b1, 9'h020, 32'hCAFE0001);
    u0If.cpu_funct3 = 3'b010;
    u0If.dma_funct3 = 3'b010;
    u0If.mem_rdata  = 32'h0000_1234;
    u1If.cpu_req    = 1'b0;
    u1If.cpu_we     = 1'b0;
    u1If.cpu_addr   = '0;
    u1If.cpu_wdata  = '0;
    u1If.cpu_funct3 = '0;
    u1If.dma_req    = 1'b0;
    u1If.dma_we     = 1'b0;
    u1If.dma_addr   = '0;
    u1If.dma_wdata  = '0;
    u1If.dma_funct3 = '0;
    u1If.mem_rdata  = 32'hA5A5_0F0F;

    $display("[TB] reset held with both requesters active");
    for (int c = 0; c < 2; c++) begin
      settle();
      checkOutput("rst_stall", {31'b0, u0If.cpu_stall}, 32'd0);
      checkOutput("rst_mem_wr", {31'b0, u0If.mem_wr}, 32'd0);
      checkOutput("rst_mem_rd", {31'b0, u0If.mem_rd}, 32'd0);
      checkOutput("rst_dma_gnt", {31'b0, u0If.dma_gnt}, 32'd0);
      checkOutput("rst_mem_addr", {23'b0, u0If.mem_addr}, 32'd0);
      if (c == 0) nextCycle();
    end

    $display("[TB] starvation: CPU wins three, DMA wins the fourth");
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      reset = 1'b0;
      settle();
      if ((k % 4) == 0) begin
        checkOutput("starve_dma_gnt", {31'b0, u0If.dma_gnt}, 32'd1);
        checkOutput("starve_cpu_stall", {31'b0, u0If.cpu_stall}, 32'd1);
        checkOutput("starve_addr", {23'b0, u0If.mem_addr}, 32'h20);
        checkOutput("starve_wdata", u0If.mem_wdata, 32'hCAFE0001);
      end else begin
        checkOutput("starve_dma_gnt", {31'b0, u0If.dma_gnt}, 32'd0);
        checkOutput("starve_cpu_stall", {31'b0, u0If.cpu_stall}, 32'd0);
        checkOutput("starve_addr", {23'b0, u0If.mem_addr}, 32'h10);
        checkOutput("starve_wdata", u0If.mem_wdata, 32'hDEADBEEF);
      end
      checkOutput("starve_mem_wr", {31'b0, u0If.mem_wr}, 32'd1);
    end

    $display("[TB] lone CPU write");
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    checkOutput("wr_mem_wr", {31'b0, u0If.mem_wr}, 32'd1);
    checkOutput("wr_mem_rd", {31'b0, u0If.mem_rd}, 32'd0);
    checkOutput("wr_addr", {23'b0, u0If.mem_addr}, 32'h10);
    checkOutput("wr_wdata", u0If.mem_wdata, 32'hDEADBEEF);
    checkOutput("wr_stall", {31'b0, u0If.cpu_stall}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    checkOutput("idle_mem_wr", {31'b0, u0If.mem_wr}, 32'd0);
    checkOutput("idle_mem_rd", {31'b0, u0If.mem_rd}, 32'd0);
    checkOutput("idle_stall", {31'b0, u0If.cpu_stall}, 32'd0);
    checkOutput("idle_addr", {23'b0, u0If.mem_addr}, 32'd0);

    $display("[TB] CPU read with two-cycle latency");
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h044, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    checkOutput("rd_t0_stall", {31'b0, u0If.cpu_stall}, 32'd1);
    checkOutput("rd_t0_mem_rd", {31'b0, u0If.mem_rd}, 32'd1);
    checkOutput("rd_t0_rvalid", {31'b0, u0If.cpu_rvalid}, 32'd0);
    checkOutput("rd_t0_addr", {23'b0, u0If.mem_addr}, 32'h44);
    nextCycle();
    settle();
    checkOutput("rd_t1_stall", {31'b0, u0If.cpu_stall}, 32'd1);
    checkOutput("rd_t1_mem_rd", {31'b0, u0If.mem_rd}, 32'd1);
    checkOutput("rd_t1_rvalid", {31'b0, u0If.cpu_rvalid}, 32'd0);
    checkOutput("rd_t1_rdata", u0If.cpu_rdata, 32'd0);
    nextCycle();
    settle();
    checkOutput("rd_t2_stall", {31'b0, u0If.cpu_stall}, 32'd0);
    checkOutput("rd_t2_mem_rd", {31'b0, u0If.mem_rd}, 32'd1);
    checkOutput("rd_t2_mem_wr", {31'b0, u0If.mem_wr}, 32'd0);
    checkOutput("rd_t2_rvalid", {31'b0, u0If.cpu_rvalid}, 32'd1);
    checkOutput("rd_t2_rdata", u0If.cpu_rdata, 32'h1234);
    checkOutput("rd_t2_funct3", {29'b0, u0If.mem_funct3}, 32'd2);
    checkOutput("rd_t2_addr", {23'b0, u0If.mem_addr}, 32'h44);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    checkOutput("rd_t3_mem_rd", {31'b0, u0If.mem_rd}, 32'd0);
    checkOutput("rd_t3_rvalid", {31'b0, u0If.cpu_rvalid}, 32'd0);

    $display("[TB] reset during an outstanding read");
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h0A0, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    checkOutput("rr_issue_mem_rd", {31'b0, u0If.mem_rd}, 32'd1);
    nextCycle();
    reset = 1'b1;
    settle();
    checkOutput("rr_rst_mem_rd", {31'b0, u0If.mem_rd}, 32'd0);
    checkOutput("rr_rst_rvalid", {31'b0, u0If.cpu_rvalid}, 32'd0);
    checkOutput("rr_rst_stall", {31'b0, u0If.cpu_stall}, 32'd0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    checkOutput("rr_after_mem_rd", {31'b0, u0If.mem_rd}, 32'd0);
    checkOutput("rr_after_rvalid", {31'b0, u0If.cpu_rvalid}, 32'd0);

    $display("[TB] DMA read beats a CPU write when DMA always wins contention");
    nextCycle();
    u1If.dma_req    = 1'b1;
    u1If.dma_we     = 1'b0;
    u1If.dma_addr   = 9'h080;
    u1If.dma_funct3 = 3'b100;
    u1If.cpu_req    = 1'b1;
    u1If.cpu_we     = 1'b1;
    u1If.cpu_addr   = 9'h011;
    u1If.cpu_wdata  = 32'h0BAD_F00D;
    settle();
    checkOutput("dma_t0_gnt", {31'b0, u1If.dma_gnt}, 32'd1);
    checkOutput("dma_t0_mem_rd", {31'b0, u1If.mem_rd}, 32'd1);
    checkOutput("dma_t0_mem_wr", {31'b0, u1If.mem_wr}, 32'd0);
    checkOutput("dma_t0_addr", {23'b0, u1If.mem_addr}, 32'h80);
    checkOutput("dma_t0_stall", {31'b0, u1If.cpu_stall}, 32'd1);
    checkOutput("dma_t0_rvalid", {31'b0, u1If.dma_rvalid}, 32'd0);
    nextCycle();
    u1If.dma_req = 1'b0;
    settle();
    checkOutput("dma_t1_rvalid", {31'b0, u1If.dma_rvalid}, 32'd1);
    checkOutput("dma_t1_rdata", u1If.dma_rdata, 32'hA5A50F0F);
    checkOutput("dma_t1_gnt", {31'b0, u1If.dma_gnt}, 32'd0);
    checkOutput("dma_t1_stall", {31'b0, u1If.cpu_stall}, 32'd1);
    checkOutput("dma_t1_cpu_rvalid", {31'b0, u1If.cpu_rvalid}, 32'd0);
    checkOutput("dma_t1_cpu_rdata", u1If.cpu_rdata, 32'd0);
    checkOutput("dma_t1_funct3", {29'b0, u1If.mem_funct3}, 32'd4);
    nextCycle();
    settle();
    checkOutput("dma_t2_mem_wr", {31'b0, u1If.mem_wr}, 32'd1);
    checkOutput("dma_t2_addr", {23'b0, u1If.mem_addr}, 32'h11);
    checkOutput("dma_t2_wdata", u1If.mem_wdata, 32'h0BADF00D);
    checkOutput("dma_t2_stall", {31'b0, u1If.cpu_stall}, 32'd0);
    checkOutput("dma_t2_rvalid", {31'b0, u1If.dma_rvalid}, 32'd0);
    checkOutput("dma_t2_rdata", u1If.dma_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
